// File: rtl/button_debouncer.sv
// Push-button input conditioner: pin inversion, two-flop synchroniser and a
// saturating-count FSM that emits a clean level plus one-cycle rise/fall strobes.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    // state      | meaning
    // IDLE_LOW   | settled released, level = 0
    // WAIT_HIGH  | counting consecutive pressed samples
    // IDLE_HIGH  | settled pressed, level = 1
    // WAIT_LOW   | counting consecutive released samples
    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

    logic                 in_n;
    logic                 s1;
    logic                 s2;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] count;

    assign in_n = btn_raw ^ ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in_n;
            s2 <= s1;
        end
    end

    // Pulses default low every cycle so each strobe lasts exactly one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE_LOW;
            count      <= CNT_ZERO;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s2) begin
                        state <= WAIT_HIGH;
                        count <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (!s2) begin
                        state <= IDLE_LOW;
                        count <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state      <= IDLE_HIGH;
                        count      <= CNT_ZERO;
                        level      <= 1'b1;
                        rise_pulse <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!s2) begin
                        state <= WAIT_LOW;
                        count <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_LOW: begin
                    if (s2) begin
                        state <= IDLE_HIGH;
                        count <= CNT_ZERO;
                        busy  <= 1'b0;
                    end else if (count == CNT_LAST) begin
                        state      <= IDLE_LOW;
                        count      <= CNT_ZERO;
                        level      <= 1'b0;
                        fall_pulse <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        count <= count + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    count <= CNT_ZERO;
                    level <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, CNT_WIDTH=3,
// active-low pin; expected values are hand-derived edge by edge.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic level;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int total      = 0;
    int passed     = 0;
    int rise_seen  = 0;
    int fall_seen  = 0;
    int both_high  = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH      (3),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .level     (level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rise_pulse) rise_seen++;
        if (fall_pulse) fall_seen++;
        if (rise_pulse && fall_pulse) both_high++;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input int lv, input int rp,
                              input int fp, input int bz);
        check({tag, ".level"}, int'(level), lv);
        check({tag, ".rise"},  int'(rise_pulse), rp);
        check({tag, ".fall"},  int'(fall_pulse), fp);
        check({tag, ".busy"},  int'(busy), bz);
    endtask

    initial begin
        // Reset held 3 cycles with pin released.
        rst = 1'b1;
        btn_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outs("reset", 0, 0, 0, 0);
        end
        check("reset.count", int'(dut.count), 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_outs("idle", 0, 0, 0, 0);
        end

        // Clean press: pin goes low before edge k.
        btn_raw = 1'b0;
        step();  // k
        check_outs("press_k", 0, 0, 0, 0);
        step();  // k+1
        check_outs("press_k1", 0, 0, 0, 0);
        step();  // k+2
        check_outs("press_k2", 0, 0, 0, 1);
        check("press_k2.count", int'(dut.count), 1);
        step();  // k+3
        check("press_k3.count", int'(dut.count), 2);
        step();  // k+4
        check_outs("press_k4", 0, 0, 0, 1);
        check("press_k4.count", int'(dut.count), 3);
        step();  // k+5
        check_outs("press_k5", 1, 1, 0, 0);
        step();  // k+6
        check_outs("press_k6", 1, 0, 0, 0);
        check("press.rise_seen", rise_seen, 1);

        // Long hold.
        for (int i = 0; i < 50; i++) begin
            step();
            check_outs("hold", 1, 0, 0, 0);
            check("hold.count", int'(dut.count), 0);
        end
        check("hold.rise_seen", rise_seen, 1);

        // Release after press.
        btn_raw = 1'b1;
        step(4); // k+3
        check_outs("rel_k3", 1, 0, 0, 1);
        step();  // k+4
        check_outs("rel_k4", 1, 0, 0, 1);
        step();  // k+5
        check_outs("rel_k5", 0, 0, 1, 0);
        step();  // k+6
        check_outs("rel_k6", 0, 0, 0, 0);
        check("rel.fall_seen", fall_seen, 1);
        check("rel.rise_seen", rise_seen, 1);
        step(5);

        // Bounce: pressed runs of 1, 2 and 3 cycles separated by releases.
        btn_raw = 1'b0; step();
        check("bounce.level", int'(level), 0);
        btn_raw = 1'b1; step();
        check("bounce.level", int'(level), 0);
        btn_raw = 1'b0; step(2);
        check("bounce.level", int'(level), 0);
        btn_raw = 1'b1; step(2);
        check("bounce.level", int'(level), 0);
        btn_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bounce.level", int'(level), 0);
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bounce.level", int'(level), 0);
        end
        check_outs("bounce_end", 0, 0, 0, 0);
        check("bounce.rise_seen", rise_seen, 1);
        check("bounce.fall_seen", fall_seen, 1);

        // Reset mid-count: press, then reset when count = 2.
        btn_raw = 1'b0;
        step(4); // k+3
        check_outs("rmid_k3", 0, 0, 0, 1);
        check("rmid_k3.count", int'(dut.count), 2);
        rst = 1'b1;
        step();  // k+4
        check_outs("rmid_rst", 0, 0, 0, 0);
        check("rmid_rst.count", int'(dut.count), 0);
        rst = 1'b0;
        step();  // j
        check_outs("rmid_j", 0, 0, 0, 0);
        step();  // j+1
        check_outs("rmid_j1", 0, 0, 0, 0);
        step();  // j+2
        check_outs("rmid_j2", 0, 0, 0, 1);
        step(2); // j+4
        check_outs("rmid_j4", 0, 0, 0, 1);
        step();  // j+5
        check_outs("rmid_j5", 1, 1, 0, 0);
        step();
        check_outs("rmid_j6", 1, 0, 0, 0);
        check("rmid.rise_seen", rise_seen, 2);
        check("rmid.fall_seen", fall_seen, 1);
        check("both_pulses_high", both_high, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
